program_loader: RTL and testbench

//  Sequences an external program download into the CPU's 16x8 RAM. On start it

---
 rtl/program_loader.sv | 145 ++++++++++++++
 tb/tb_program_loader.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program download sequencer: freezes the CPU at an instruction boundary, streams
// LEN bytes into RAM addresses 0..LEN-1, then pulses the CPU reset.
module program_loader #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int LEN         = 16,
    parameter int GAP_TIMEOUT = 1024,
    parameter int RST_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              cpu_hold,
    input  logic              cpu_idle,
    output logic              cpu_rst,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int GAP_W  = $clog2(GAP_TIMEOUT);
    localparam int RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LEN - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TIMEOUT - 1);
    localparam logic [RCNT_W-1:0] RST_LAST  = RCNT_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        LOAD,
        WRITE,
        CPURST,
        DONE,
        ABORT
    } state_t;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   addr, addr_d;
    logic [GAP_W-1:0]    gap, gap_d;
    logic [RCNT_W-1:0]   rst_cnt, rst_cnt_d;
    logic [DATA_W-1:0]   byte_q, byte_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr    <= '0;
            gap     <= '0;
            rst_cnt <= '0;
            byte_q  <= '0;
        end else begin
            state   <= state_d;
            addr    <= addr_d;
            gap     <= gap_d;
            rst_cnt <= rst_cnt_d;
            byte_q  <= byte_d;
        end
    end

    // Outputs depend only on the registered state, never directly on inputs.
    always_comb begin
        state_d   = state;
        addr_d    = addr;
        gap_d     = gap;
        rst_cnt_d = rst_cnt;
        byte_d    = byte_q;
        in_ready  = 1'b0;
        cpu_hold  = 1'b0;
        cpu_rst   = 1'b0;
        ram_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;

        case (state)
            IDLE: begin
                if (start) state_d = HOLD;
            end
            HOLD: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                if (cpu_idle) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    gap_d   = '0;
                end
            end
            LOAD: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                in_ready = 1'b1;
                // A byte arriving in the final timeout cycle is still accepted.
                if (in_valid) begin
                    byte_d  = in_data;
                    gap_d   = '0;
                    state_d = WRITE;
                end else if (gap == GAP_LAST) begin
                    state_d = ABORT;
                end else begin
                    gap_d = gap + GAP_W'(1);
                end
            end
            WRITE: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                ram_we   = 1'b1;
                if (addr == LAST_ADDR) begin
                    rst_cnt_d = '0;
                    state_d   = CPURST;
                end else begin
                    addr_d  = addr + ADDR_W'(1);
                    state_d = LOAD;
                end
            end
            CPURST: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                cpu_rst  = 1'b1;
                if (rst_cnt == RST_LAST) state_d = DONE;
                else                     rst_cnt_d = rst_cnt + RCNT_W'(1);
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            ABORT: begin
                busy    = 1'b1;
                error   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_addr  = addr;
    assign ram_wdata = byte_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a download-level reference model is
// compared against the DUT every cycle, with literal spot checks on key scenarios.
module tb_program_loader;

    localparam int ADDR_W      = 4;
    localparam int DATA_W      = 8;
    localparam int LEN         = 16;
    localparam int GAP_TIMEOUT = 24;
    localparam int RST_CYCLES  = 4;

    localparam int P_IDLE   = 0;
    localparam int P_HOLD   = 1;
    localparam int P_LOAD   = 2;
    localparam int P_WRITE  = 3;
    localparam int P_CPURST = 4;
    localparam int P_DONE   = 5;
    localparam int P_ABORT  = 6;

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              cpu_hold;
    logic              cpu_idle;
    logic              cpu_rst;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              busy;
    logic              done;
    logic              error;

    program_loader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN(LEN),
        .GAP_TIMEOUT(GAP_TIMEOUT), .RST_CYCLES(RST_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .cpu_hold(cpu_hold), .cpu_idle(cpu_idle), .cpu_rst(cpu_rst),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .busy(busy), .done(done), .error(error)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit checking = 0;

    int         m_phase    = P_IDLE;
    int         m_count    = 0;
    int         m_gap      = 0;
    int         m_rst_left = 0;
    logic [7:0] m_last     = 8'h00;
    logic [7:0] exp_ram [LEN];
    logic [7:0] dut_ram [LEN];

    int         stream_mode = 0;
    int         stop_after  = 0;
    logic [7:0] data_base   = 8'h00;

    int write_cnt, rst_hi_cnt, done_cnt, err_cnt, ready_hi_cnt, entry_cyc, err_cyc;
    bit prev_ready = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: tracks the download at the level of accepted bytes.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_phase = P_IDLE;
        end else begin
            case (m_phase)
                P_IDLE: if (start) m_phase = P_HOLD;
                P_HOLD: if (cpu_idle) begin
                    m_phase = P_LOAD;
                    m_count = 0;
                    m_gap   = 0;
                end
                P_LOAD: begin
                    if (in_valid) begin
                        m_last           = in_data;
                        exp_ram[m_count] = in_data;
                        m_count++;
                        m_gap   = 0;
                        m_phase = P_WRITE;
                    end else if (m_gap + 1 == GAP_TIMEOUT) begin
                        m_phase = P_ABORT;
                    end else begin
                        m_gap++;
                    end
                end
                P_WRITE: begin
                    if (m_count == LEN) begin
                        m_phase    = P_CPURST;
                        m_rst_left = RST_CYCLES;
                    end else begin
                        m_phase = P_LOAD;
                    end
                end
                P_CPURST: begin
                    m_rst_left--;
                    if (m_rst_left == 0) m_phase = P_DONE;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        case (stream_mode)
            1:       in_valid = 1'b1;
            2:       in_valid = (cyc % 5 == 0);
            3:       in_valid = ($urandom_range(0, 1) == 1);
            4:       in_valid = (m_count < stop_after);
            default: in_valid = 1'b0;
        endcase
        in_data = (stream_mode == 3) ? 8'($urandom) : data_base + 8'(m_count);
    end

    // Single compare point, mid-cycle, plus observers used by the literal checks.
    always @(negedge clk) begin
        if (checking) begin
            check_output("busy",     32'(busy),     32'(m_phase != P_IDLE));
            check_output("in_ready", 32'(in_ready), 32'(m_phase == P_LOAD));
            check_output("cpu_hold", 32'(cpu_hold), 32'(m_phase >= P_HOLD && m_phase <= P_CPURST));
            check_output("cpu_rst",  32'(cpu_rst),  32'(m_phase == P_CPURST));
            check_output("ram_we",   32'(ram_we),   32'(m_phase == P_WRITE));
            check_output("done",     32'(done),     32'(m_phase == P_DONE));
            check_output("error",    32'(error),    32'(m_phase == P_ABORT));
            if (m_phase == P_WRITE) begin
                check_output("ram_addr",  32'(ram_addr),  32'(m_count - 1));
                check_output("ram_wdata", 32'(ram_wdata), 32'(m_last));
            end
            if (ram_we === 1'b1) begin
                dut_ram[ram_addr] = ram_wdata;
                write_cnt++;
            end
            if (cpu_rst === 1'b1) rst_hi_cnt++;
            if (done === 1'b1) done_cnt++;
            if (error === 1'b1) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (in_ready === 1'b1) begin
                ready_hi_cnt++;
                if (!prev_ready) entry_cyc = cyc;
            end
            prev_ready = (in_ready === 1'b1);
        end
    end

    task automatic apply_stimulus(input logic s, input logic idle, input logic r);
        @(posedge clk);
        #2;
        start    = s;
        cpu_idle = idle;
        rst      = r;
    endtask

    task automatic clear_obs();
        write_cnt = 0; rst_hi_cnt = 0; done_cnt = 0; err_cnt = 0;
        ready_hi_cnt = 0; entry_cyc = 0; err_cyc = 0;
    endtask

    task automatic begin_load(input logic [7:0] base, input int mode, input int idle_delay);
        clear_obs();
        data_base   = base;
        stream_mode = mode;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        repeat (idle_delay) apply_stimulus(1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0);
    endtask

    task automatic wait_idle(input int budget, input bit noise, input string tag);
        int n = 0;
        while (m_phase != P_IDLE && n < budget) begin
            apply_stimulus(noise ? ($urandom_range(0, 2) == 0) : 1'b0, cpu_idle, 1'b0);
            n++;
        end
        start = 1'b0;
        check_output({tag, "_finished"}, 32'(m_phase == P_IDLE), 32'd1);
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < LEN; i++)
            check_output({tag, "_ram"}, 32'(dut_ram[i]), 32'(exp_ram[i]));
    endtask

    task automatic check_ram_literal(input string tag, input logic [7:0] base, input int upto);
        for (int i = 0; i < upto; i++)
            check_output({tag, "_ram_lit"}, 32'(dut_ram[i]), 32'(base + 8'(i)));
    endtask

    initial begin
        int n;
        for (int i = 0; i < LEN; i++) begin
            exp_ram[i] = 8'h00;
            dut_ram[i] = 8'h00;
        end
        rst = 1'b1; start = 1'b0; cpu_idle = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        clear_obs();

        apply_stimulus(1'b0, 1'b0, 1'b1);
        checking = 1;
        repeat (2) apply_stimulus(1'b0, 1'b0, 1'b1);
        check_output("reset_outputs",
                     32'({in_ready, cpu_hold, cpu_rst, ram_we, busy, done, error}), 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] full load");
        begin_load(8'h10, 1, 3);
        wait_idle(200, 1'b0, "full");
        check_output("full_busy_after", 32'(busy), 32'd0);
        check_output("full_writes", 32'(write_cnt), 32'd16);
        check_output("full_cpu_rst_cycles", 32'(rst_hi_cnt), 32'd4);
        check_output("full_done_pulses", 32'(done_cnt), 32'd1);
        check_output("full_error_pulses", 32'(err_cnt), 32'd0);
        check_ram_literal("full", 8'h10, 16);

        $display("[TB] gapped stream with ignored starts");
        begin_load(8'h40, 2, 1);
        wait_idle(400, 1'b1, "gaps");
        check_output("gaps_writes", 32'(write_cnt), 32'd16);
        check_output("gaps_done_pulses", 32'(done_cnt), 32'd1);
        check_ram_literal("gaps", 8'h40, 16);

        $display("[TB] byte timeout");
        stop_after = 6;
        begin_load(8'h70, 4, 1);
        wait_idle(200, 1'b0, "timeout");
        check_output("timeout_error_pulses", 32'(err_cnt), 32'd1);
        check_output("timeout_writes", 32'(write_cnt), 32'd6);
        check_output("timeout_no_cpu_rst", 32'(rst_hi_cnt), 32'd0);
        check_output("timeout_no_done", 32'(done_cnt), 32'd0);
        check_output("timeout_latency", 32'(err_cyc - entry_cyc), 32'(GAP_TIMEOUT));
        check_ram_literal("timeout", 8'h70, 6);
        check_output("timeout_ram6_kept", 32'(dut_ram[6]), 32'h46);

        $display("[TB] hold wait");
        clear_obs();
        data_base   = 8'hA0;
        stream_mode = 1;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        repeat (50) apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("hold_ready_cycles", 32'(ready_hi_cnt), 32'd0);
        check_output("hold_writes", 32'(write_cnt), 32'd0);
        check_output("hold_cpu_hold", 32'(cpu_hold), 32'd1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        check_output("hold_load_entry", 32'(in_ready), 32'd1);
        wait_idle(200, 1'b0, "hold");
        check_ram_literal("hold", 8'hA0, 16);

        $display("[TB] reset mid-load");
        begin_load(8'hC0, 1, 0);
        n = 0;
        while (!(m_phase == P_WRITE && m_count == 8) && n < 100) begin
            apply_stimulus(1'b0, 1'b1, 1'b0);
            n++;
        end
        check_output("midrst_reached_byte7", 32'(m_phase == P_WRITE && m_count == 8), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #3;
        check_output("midrst_outputs",
                     32'({in_ready, cpu_hold, cpu_rst, ram_we, busy, done, error}), 32'd0);
        rst = 1'b0;
        repeat (6) apply_stimulus(1'b0, 1'b1, 1'b0);
        check_output("midrst_writes", 32'(write_cnt), 32'd8);
        check_output("midrst_idle_no_capture", 32'(busy), 32'd0);
        check_output("midrst_ram7", 32'(dut_ram[7]), 32'hC7);
        check_output("midrst_ram8_kept", 32'(dut_ram[8]), 32'hA8);
        begin_load(8'hE0, 1, 2);
        wait_idle(200, 1'b1, "reload");
        check_output("reload_writes", 32'(write_cnt), 32'd16);
        check_ram_literal("reload", 8'hE0, 16);

        $display("[TB] randomized downloads");
        for (int k = 0; k < 6; k++) begin
            stop_after = $urandom_range(1, 15);
            begin_load(8'($urandom), $urandom_range(3, 4), $urandom_range(0, 5));
            wait_idle(400, 1'b1, "rand");
            check_output("rand_outcome", 32'(done_cnt + err_cnt), 32'd1);
            check_ram("rand");
        end

        apply_stimulus(1'b0, 1'b0, 1'b0);
        checking = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
